ic_fill_ctrl: RTL and testbench
===============================

# ic_fill_ctrl

Instruction-cache line refill controller that sits directly upstream of `ic_ram_block` and drives its write port. On a miss it issues one line-aligned request to the memory side, assembles `LINE/BEAT` returning beats into a full line, and writes that line into `ic_ram_block` with a single-cycle write. It then signals completion to the fetch/miss logic.

## Interface
- `LINE`, 128: cache line width in bits; must equal `ic_ram_block` LINE.
- `DEPTH`, 1024: lines in `ic_ram_block`; `ADDR = $clog2(DEPTH)`.
- `BEAT`, 32: memory return data width; `LINE % BEAT == 0`, `BEATS = LINE/BEAT >= 2`.
- `MADDR`, 32: byte address width; `OFS = $clog2(LINE/8)`, `OFS + ADDR <= MADDR`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `miss_req` in 1: start a refill; sampled only in IDLE.
- `miss_addr` in MADDR: byte address of the missing fetch; sampled with `miss_req`.
- `busy` out 1: high in every state except IDLE.
- `fill_done` out 1: one-cycle pulse, line written.
- `fill_err` out 1: one-cycle pulse, refill aborted.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_addr` out MADDR: line-aligned request address.
- `mem_ack` in 1: request accepted.
- `mem_rvalid` in 1: `mem_rdata` valid this cycle.
- `mem_rdata` in BEAT: return beat.
- `mem_err` in 1: memory error; aborts the fill.
- `ram_en_` out 1: `ic_ram_block` enable, active-low.
- `ram_rw_` out 1: 1 = read, 0 = write.
- `ram_addr` out ADDR: line index.
- `ram_wdata` out LINE: assembled line.

## Operation
- The FSM has five states.
  - IDLE: `miss_req` latches `index = miss_addr[OFS +: ADDR]` and `mem_addr = {miss_addr[MADDR-1:OFS], OFS'b0}`, then moves to REQ.
  - REQ: `mem_req` = 1. `mem_ack` moves to RECV and drops `mem_req` the next cycle.
  - RECV: each `mem_rvalid` stores `mem_rdata` into `buf[cnt*BEAT +: BEAT]` and increments `cnt` (width `$clog2(BEATS)`, cleared on entry to REQ). The last beat (`cnt == BEATS-1`) moves to WRITE.
  - WRITE: `ram_en_` = 0, `ram_rw_` = 0, `ram_addr` = index, `ram_wdata` = buf. Lasts exactly one cycle, then DONE.
  - DONE: `fill_done` = 1 for one cycle, then IDLE.
- Beats arrive in ascending address order; beat 0 occupies the LSBs.
- `mem_rvalid` outside RECV is ignored. So is `mem_ack` outside REQ.
- `mem_err` in REQ or RECV aborts the fill:
  - next state is IDLE, no RAM write;
  - `fill_err` = 1 in that first IDLE cycle;
  - `mem_err` together with `mem_rvalid` (including the last beat): the error wins.
- `miss_req` outside IDLE is ignored. The requester holds it until it sees `fill_done` or `fill_err`.
- `ram_en_` is 0 only in WRITE. The block never issues a RAM read, so `ram_rw_` is 1 outside WRITE.
- `ram_addr`/`ram_wdata` hold their last registered values while `ram_en_` = 1.
- Reset in any state: return to IDLE, no write, no `fill_done`/`fill_err` pulse. Beats still in flight after reset are ignored.

## Timing
- All outputs are registered.
- Reset values: `busy` 0, `fill_done` 0, `fill_err` 0, `mem_req` 0, `mem_addr` 0, `ram_en_` 1, `ram_rw_` 1, `ram_addr` 0, `ram_wdata` 0. Internal `cnt` and `buf` are 0.
- `miss_req` at cycle T gives `busy` = 1 and `mem_req` = 1 at T+1.
- `mem_ack` at cycle A gives `mem_req` = 0 at A+1. With `mem_ack` already high at T+1, `mem_req` is high for exactly one cycle.
- Last beat at cycle R gives the write at R+1, `fill_done` at R+2, and IDLE at R+3. A new `miss_req` at R+3 gives `mem_req` at R+4.
- Beats may be back-to-back or gapped; gaps add no extra latency.
- Minimum miss-to-done latency is `BEATS + 3` cycles after `miss_req`, assuming ack at T+1 and beats starting at T+2.

## Test plan
- Reset values: hold `reset` for 2 cycles with `miss_req` = 1 → all outputs equal their reset values, `busy` = 0, no `mem_req`.
- Basic fill: `miss_addr` = 0x0000_1234, ack at T+1, beats 0xdeadbeef, 0xcafecafe, 0x01234567, 0x89abcdef back-to-back →
  - `mem_addr` = 0x0000_1230;
  - one write with `ram_addr` = 0x123 and `ram_wdata` = 0x89abcdef_01234567_cafecafe_deadbeef;
  - `fill_done` two cycles after the last beat.
- Gapped beats, delayed ack: ack after 3 cycles, 2 idle cycles between each beat → same line written exactly once. `ram_en_` = 0 for exactly one cycle; `mem_req` is held steady until ack.
- Error abort: `mem_err` coincident with beat 2 of 4 → `fill_err` pulse, no `ram_en_` = 0 cycle, `busy` = 0 next cycle. A follow-up miss to 0x40 then fills index 0x004 correctly.
- Ignored inputs: `miss_req` for address 0x5550 while busy, plus stray `mem_rvalid` in IDLE → only the first fill is written, `cnt` is undisturbed, no second `mem_req`.
- Reset mid-RECV: after 2 beats, reset, then feed the remaining 2 beats → no write, no pulses. A fresh fill then writes a correct line whose beat 0 is the new data.

Source files
------------

// File: rtl/ic_fill_ctrl.sv
// rtl/ic_fill_ctrl.sv - instruction-cache line refill controller driving the ic_ram_block write port
module ic_fill_ctrl #(
    parameter int LINE  = 128,
    parameter int DEPTH = 1024,
    parameter int BEAT  = 32,
    parameter int MADDR = 32,
    localparam int ADDR = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss_req,
    input  logic [MADDR-1:0] miss_addr,
    output logic             busy,
    output logic             fill_done,
    output logic             fill_err,
    output logic             mem_req,
    output logic [MADDR-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic             mem_rvalid,
    input  logic [BEAT-1:0]  mem_rdata,
    input  logic             mem_err,
    output logic             ram_en_,
    output logic             ram_rw_,
    output logic [ADDR-1:0]  ram_addr,
    output logic [LINE-1:0]  ram_wdata
);

    localparam int BEATS = LINE / BEAT;
    localparam int OFS   = $clog2(LINE / 8);
    localparam int CW    = $clog2(BEATS);
    localparam logic [MADDR-1:0] OFS_MASK = MADDR'((64'd1 << OFS) - 64'd1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [LINE-1:0]   line_buf, line_buf_d;
    logic [ADDR-1:0]   index, index_d;
    logic [MADDR-1:0]  mem_addr_d;
    logic [ADDR-1:0]   ram_addr_d;
    logic [LINE-1:0]   ram_wdata_d;
    logic              fill_err_d;

    // Next state and next values of every registered output and datapath register.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        line_buf_d  = line_buf;
        index_d     = index;
        mem_addr_d  = mem_addr;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        fill_err_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (miss_req) begin
                    state_d    = S_REQ;
                    index_d    = miss_addr[OFS +: ADDR];
                    mem_addr_d = miss_addr & ~OFS_MASK;
                    cnt_d      = '0;
                end
            end
            S_REQ: begin
                if (mem_err) begin
                    state_d    = S_IDLE;
                    fill_err_d = 1'b1;
                end else if (mem_ack) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                // An error beat is never stored: the abort takes priority over data.
                if (mem_err) begin
                    state_d    = S_IDLE;
                    fill_err_d = 1'b1;
                end else if (mem_rvalid) begin
                    line_buf_d[int'(cnt) * BEAT +: BEAT] = mem_rdata;
                    cnt_d = cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        state_d     = S_WRITE;
                        ram_addr_d  = index;
                        ram_wdata_d = line_buf_d;
                    end
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            line_buf  <= '0;
            index     <= '0;
            mem_addr  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            mem_req   <= 1'b0;
            ram_en_   <= 1'b1;
            ram_rw_   <= 1'b1;
        end else begin
            cnt       <= cnt_d;
            line_buf  <= line_buf_d;
            index     <= index_d;
            mem_addr  <= mem_addr_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            busy      <= (state_d != S_IDLE);
            fill_done <= (state_d == S_DONE);
            fill_err  <= fill_err_d;
            mem_req   <= (state_d == S_REQ);
            ram_en_   <= (state_d != S_WRITE);
            ram_rw_   <= (state_d != S_WRITE);
        end
    end

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// tb/tb_ic_fill_ctrl.sv - self-checking bench for ic_fill_ctrl against a transaction-level model
module tb_ic_fill_ctrl;

    localparam int LINE  = 128;
    localparam int DEPTH = 1024;
    localparam int BEAT  = 32;
    localparam int MADDR = 32;
    localparam int ADDR  = 10;
    localparam int BEATS = 4;
    localparam int OFS   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             miss_req;
    logic [MADDR-1:0] miss_addr;
    logic             busy, fill_done, fill_err, mem_req;
    logic [MADDR-1:0] mem_addr;
    logic             mem_ack, mem_rvalid, mem_err;
    logic [BEAT-1:0]  mem_rdata;
    logic             ram_en_, ram_rw_;
    logic [ADDR-1:0]  ram_addr;
    logic [LINE-1:0]  ram_wdata;

    always #5 clk = ~clk;

    ic_fill_ctrl #(.LINE(LINE), .DEPTH(DEPTH), .BEAT(BEAT), .MADDR(MADDR)) dut (
        .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
        .busy(busy), .fill_done(fill_done), .fill_err(fill_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .ram_en_(ram_en_), .ram_rw_(ram_rw_), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: a refill is "in flight" until its beats are collected,
    // then the write/done/idle steps follow on a fixed timeline counted in cycles.
    int               cyc = 0;
    logic             m_busy, m_req, m_done, m_err, m_wr;
    logic [MADDR-1:0] m_addr;
    logic [ADDR-1:0]  m_idx, m_raddr;
    logic [LINE-1:0]  m_wdata, m_line;
    bit               acked;
    int               tail;
    logic [BEAT-1:0]  beats_q[$];

    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_wr   = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_req = 1'b0; m_addr = '0; m_raddr = '0; m_wdata = '0;
            tail = 0; acked = 1'b0; beats_q.delete();
        end else if (!m_busy) begin
            if (miss_req) begin
                m_busy = 1'b1; m_req = 1'b1;
                m_addr = (miss_addr >> OFS) << OFS;
                m_idx  = ADDR'((miss_addr >> OFS) % DEPTH);
                acked  = 1'b0; beats_q.delete();
            end
        end else if (tail > 0) begin
            tail++;
            if (tail == 2) m_done = 1'b1;
            if (tail == 3) begin m_busy = 1'b0; tail = 0; end
        end else if (mem_err) begin
            m_busy = 1'b0; m_req = 1'b0; m_err = 1'b1;
        end else if (!acked) begin
            if (mem_ack) begin acked = 1'b1; m_req = 1'b0; end
        end else if (mem_rvalid) begin
            beats_q.push_back(mem_rdata);
            if (beats_q.size() == BEATS) begin
                m_line = '0;
                foreach (beats_q[i]) m_line = m_line | (LINE'(beats_q[i]) << (BEAT * i));
                m_wr = 1'b1; m_raddr = m_idx; m_wdata = m_line; tail = 1;
            end
        end
    end

    int               writes = 0, dones = 0, errs = 0, req_starts = 0;
    logic             prev_req = 1'b0;
    logic [ADDR-1:0]  last_waddr;
    logic [LINE-1:0]  last_wdata;
    logic [MADDR-1:0] req_addr;
    int               done_cyc = 0;

    // Per-cycle comparison of every output against the model, plus event bookkeeping.
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy", busy, m_busy);
            chk("mem_req", mem_req, m_req);
            chk("mem_addr", mem_addr, m_addr);
            chk("fill_done", fill_done, m_done);
            chk("fill_err", fill_err, m_err);
            chk("ram_en_", ram_en_, !m_wr);
            chk("ram_rw_", ram_rw_, !m_wr);
            chk("ram_addr", ram_addr, m_raddr);
            chk("ram_wdata", ram_wdata, m_wdata);
            if (!ram_en_) begin writes++; last_waddr = ram_addr; last_wdata = ram_wdata; end
            if (fill_done) begin dones++; done_cyc = cyc; end
            if (fill_err) errs++;
            if (mem_req && !prev_req) begin req_starts++; req_addr = mem_addr; end
            prev_req = mem_req;
        end
    end

    int miss_cyc, beat_cyc;

    task automatic wait_idle();
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        chk("idle_timeout", busy, 1'b0);
    endtask

    // Called at a negedge; err_beat: -1 none, 0..3 error on that beat, 9 error while requesting.
    task automatic fill(input logic [MADDR-1:0] addr, input int ack_dly, input int gap,
                        input int err_beat, input logic [LINE-1:0] data, input bit stray);
        miss_req = 1'b1; miss_addr = addr; miss_cyc = cyc;
        @(negedge clk);
        miss_req = 1'b0;
        if (stray) begin miss_req = 1'b1; miss_addr = 32'h0000_5550; end
        if (err_beat == 9) begin
            mem_err = 1'b1;
            @(negedge clk);
            mem_err = 1'b0;
        end else begin
            repeat (ack_dly) @(negedge clk);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            for (int i = 0; i < BEATS; i++) begin
                repeat (gap) @(negedge clk);
                mem_rvalid = 1'b1; mem_rdata = data[i*BEAT +: BEAT];
                mem_err = (i == err_beat); beat_cyc = cyc;
                @(negedge clk);
                mem_rvalid = 1'b0; mem_err = 1'b0;
                if (i == err_beat) break;
            end
        end
        miss_req = 1'b0;
        wait_idle();
    endtask

    task automatic noise(input int n);
        repeat (n) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_ack    = 1'($urandom_range(0, 1));
            mem_err    = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            @(negedge clk);
        end
        mem_rvalid = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
    endtask

    localparam logic [LINE-1:0] BASIC = 128'h89abcdef_01234567_cafecafe_deadbeef;
    localparam logic [LINE-1:0] NEWL  = 128'h44444444_33333333_22222222_11111111;

    initial begin
        int w0, d0, e0, r0;
        reset = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_1234;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_ram_en_", ram_en_, 1'b1);
        chk("rst_ram_wdata", ram_wdata, '0);
        reset = 1'b0; miss_req = 1'b0;

        // Basic back-to-back fill.
        w0 = writes; d0 = dones;
        fill(32'h0000_1234, 0, 0, -1, BASIC, 1'b0);
        #1;
        chk("basic_mem_addr", req_addr, 32'h0000_1230);
        chk("basic_writes", writes - w0, 1);
        chk("basic_waddr", last_waddr, 10'h123);
        chk("basic_wdata", last_wdata, BASIC);
        chk("basic_done_lat", done_cyc - beat_cyc, 2);
        chk("basic_min_lat", done_cyc - miss_cyc, BEATS + 3);
        chk("basic_dones", dones - d0, 1);

        // Delayed ack, gapped beats.
        w0 = writes; r0 = req_starts;
        fill(32'h0000_1234, 3, 2, -1, BASIC, 1'b0);
        #1;
        chk("gap_writes", writes - w0, 1);
        chk("gap_wdata", last_wdata, BASIC);
        chk("gap_req_starts", req_starts - r0, 1);
        chk("gap_done_lat", done_cyc - beat_cyc, 2);

        // Error on beat 2, then a clean follow-up fill.
        w0 = writes; e0 = errs;
        fill(32'h0000_3000, 0, 0, 2, BASIC, 1'b0);
        #1;
        chk("err_pulse", fill_err, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_no_write", writes - w0, 0);
        @(negedge clk);
        #1;
        chk("err_count", errs - e0, 1);
        fill(32'h0000_0040, 0, 0, -1, NEWL, 1'b0);
        #1;
        chk("after_err_waddr", last_waddr, 10'h004);
        chk("after_err_wdata", last_wdata, NEWL);

        // Stray rvalid in IDLE, then a miss held while busy.
        mem_rvalid = 1'b1; mem_rdata = 32'hffff_ffff;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        w0 = writes; r0 = req_starts;
        fill(32'h0000_1234, 1, 0, -1, BASIC, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("ign_writes", writes - w0, 1);
        chk("ign_req_starts", req_starts - r0, 1);
        chk("ign_wdata", last_wdata, BASIC);

        // Reset during RECV with leftover beats afterwards.
        w0 = writes; d0 = dones; e0 = errs;
        miss_req = 1'b1; miss_addr = 32'h0000_2000;
        @(negedge clk);
        miss_req = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1; mem_rdata = BASIC[i*BEAT +: BEAT];
            @(negedge clk);
        end
        mem_rvalid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 2; i < BEATS; i++) begin
            mem_rvalid = 1'b1; mem_rdata = BASIC[i*BEAT +: BEAT];
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rstmid_writes", writes - w0, 0);
        chk("rstmid_pulses", (dones - d0) + (errs - e0), 0);
        fill(32'h0000_2000, 0, 1, -1, NEWL, 1'b0);
        #1;
        chk("rstmid_refill_waddr", last_waddr, 10'h200);
        chk("rstmid_refill_wdata", last_wdata, NEWL);

        // Randomized fills with idle noise in between.
        for (int n = 0; n < 30; n++) begin
            int r, eb;
            r  = $urandom_range(0, 9);
            eb = (r == 0) ? $urandom_range(0, 3) : ((r == 1) ? 9 : -1);
            fill($urandom, $urandom_range(0, 3), $urandom_range(0, 2), eb,
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
            noise($urandom_range(0, 2));
        end
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
